// File: rtl/mem_arbiter_pkg.sv
// Shared types and defaults for the two-port memory arbiter.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_t;

    localparam int MAXBURST_DEFAULT = 4;

endpackage

// File: rtl/mem_arbiter.sv
// Two-port (CPU / loader) arbiter in front of a single-port memory with
// burst-limited round-robin ownership and registered read return.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int MAXBURST = MAXBURST_DEFAULT,
    parameter int WIDTH    = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0,
    input  logic             we0,
    input  logic [WIDTH-1:0] adr0,
    input  logic [WIDTH-1:0] wd0,
    input  logic             req1,
    input  logic             we1,
    input  logic [WIDTH-1:0] adr1,
    input  logic [WIDTH-1:0] wd1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             rvalid0,
    output logic             rvalid1,
    output logic [WIDTH-1:0] rd0,
    output logic [WIDTH-1:0] rd1,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_adr,
    output logic [WIDTH-1:0] mem_wd,
    input  logic [WIDTH-1:0] mem_rd
);

    localparam int            CW   = $clog2(MAXBURST + 1);
    localparam logic [CW-1:0] CMAX = CW'(MAXBURST);

    arb_state_t    state;
    arb_state_t    other_state;
    logic          prio;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;
    logic          own_req;
    logic          other_req;
    logic          burst_done;

    // NOTE: every signal driven in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        gnt0        = (state == OWN0) && req0;
        gnt1        = (state == OWN1) && req1;
        own_req     = (state == OWN1) ? req1 : req0;
        other_req   = (state == OWN1) ? req0 : req1;
        other_state = (state == OWN0) ? OWN1 : OWN0;
        cnt_next    = (cnt == CMAX) ? cnt : cnt + CW'(1);
        burst_done  = (cnt_next == CMAX);
    end

    always_comb begin
        mem_we  = 1'b0;
        mem_adr = '0;
        mem_wd  = '0;
        if (gnt0) begin
            mem_we  = we0;
            mem_adr = adr0;
            mem_wd  = wd0;
        end else if (gnt1) begin
            mem_we  = we1;
            mem_adr = adr1;
            mem_wd  = wd1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            prio  <= 1'b0;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (req0 && req1)
                        state <= prio ? OWN1 : OWN0;
                    else if (req0)
                        state <= OWN0;
                    else if (req1)
                        state <= OWN1;
                end
                OWN0, OWN1: begin
                    if (!own_req) begin
                        state <= other_req ? other_state : IDLE;
                        prio  <= (state == OWN0);
                        cnt   <= '0;
                    end else if (burst_done && other_req) begin
                        // Hand over straight after the last burst access: no idle gap.
                        state <= other_state;
                        prio  <= (state == OWN0);
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt_next;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
            rd0     <= '0;
            rd1     <= '0;
        end else begin
            rvalid0 <= gnt0 && !we0;
            rvalid1 <= gnt1 && !we1;
            if (gnt0 && !we0)
                rd0 <= mem_rd;
            if (gnt1 && !we1)
                rd1 <= mem_rd;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench: single read, simultaneous start, burst fairness, solo burst,
// write, reset mid-burst, plus a MAXBURST=1 instance for strict alternation.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    logic        clk;
    logic        reset;
    logic        req0, we0, req1, we1;
    logic [31:0] adr0, wd0, adr1, wd1;
    logic        gnt0, gnt1, rvalid0, rvalid1, mem_we;
    logic [31:0] rd0, rd1, mem_adr, mem_wd, mem_rd;
    logic        b_gnt0, b_gnt1, b_rvalid0, b_rvalid1, b_mem_we;
    logic [31:0] b_rd0, b_rd1, b_mem_adr, b_mem_wd, b_mem_rd;
    logic [31:0] mem [0:255];

    int checks = 0;
    int errors = 0;

    mem_arbiter #(.MAXBURST(4), .WIDTH(32)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .we0(we0), .adr0(adr0), .wd0(wd0),
        .req1(req1), .we1(we1), .adr1(adr1), .wd1(wd1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rd0(rd0), .rd1(rd1), .mem_we(mem_we), .mem_adr(mem_adr),
        .mem_wd(mem_wd), .mem_rd(mem_rd)
    );

    mem_arbiter #(.MAXBURST(1), .WIDTH(32)) dut_b1 (
        .clk(clk), .reset(reset),
        .req0(req0), .we0(we0), .adr0(adr0), .wd0(wd0),
        .req1(req1), .we1(we1), .adr1(adr1), .wd1(wd1),
        .gnt0(b_gnt0), .gnt1(b_gnt1), .rvalid0(b_rvalid0), .rvalid1(b_rvalid1),
        .rd0(b_rd0), .rd1(b_rd1), .mem_we(b_mem_we), .mem_adr(b_mem_adr),
        .mem_wd(b_mem_wd), .mem_rd(b_mem_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_rd   = mem[mem_adr[9:2]];
    assign b_mem_rd = 32'h0;

    always @(posedge clk)
        if (mem_we)
            mem[mem_adr[9:2]] <= mem_wd;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_gnt0"}, 32'(gnt0), 32'h0);
        check({tag, "_gnt1"}, 32'(gnt1), 32'h0);
        check({tag, "_mem_we"}, 32'(mem_we), 32'h0);
        check({tag, "_rvalid0"}, 32'(rvalid0), 32'h0);
        check({tag, "_rvalid1"}, 32'(rvalid1), 32'h0);
        check({tag, "_state"}, 32'(dut.state), 32'(IDLE));
        check({tag, "_cnt"}, 32'(dut.cnt), 32'h0);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_reset_outputs("rst");
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        logic g0, g1, pg0, pg1;

        for (int i = 0; i < 256; i++)
            mem[i] = 32'hA500_0000 | i;
        mem[4] = 32'h0000_1234;

        reset = 1'b0;
        req0 = 1'b0; we0 = 1'b0; adr0 = '0; wd0 = '0;
        req1 = 1'b0; we1 = 1'b0; adr1 = '0; wd1 = '0;
        #1;
        check_reset_outputs("por");
        check("por_rd0", rd0, 32'h0);
        check("por_rd1", rd1, 32'h0);
        check("por_prio", 32'(dut.prio), 32'h0);
        @(negedge clk);
        reset = 1'b1;

        // Single read of word 4
        tick();
        req0 = 1'b1; adr0 = 32'h10;
        #1;
        check("rd_c0_gnt0", 32'(gnt0), 32'h0);
        tick(); #1;
        check("rd_c1_gnt0", 32'(gnt0), 32'h1);
        check("rd_c1_adr", mem_adr, 32'h10);
        check("rd_c1_we", 32'(mem_we), 32'h0);
        check("rd_c1_rvalid0", 32'(rvalid0), 32'h0);
        tick();
        req0 = 1'b0; adr0 = '0;
        #1;
        check("rd_c2_rvalid0", 32'(rvalid0), 32'h1);
        check("rd_c2_rd0", rd0, 32'h0000_1234);
        check("rd_c2_gnt0", 32'(gnt0), 32'h0);
        tick(); #1;
        check("rd_c3_rvalid0", 32'(rvalid0), 32'h0);
        check("rd_c3_state", 32'(dut.state), 32'(IDLE));

        // Both ports from a fresh reset: 4/4/4 bursts; MAXBURST=1 alternates
        apply_reset();
        pg0 = 1'b0; pg1 = 1'b0;
        for (int c = 0; c <= 12; c++) begin
            tick();
            if (c == 0) begin
                req0 = 1'b1; adr0 = 32'h00;
                req1 = 1'b1; adr1 = 32'h40;
            end
            #1;
            g0 = (c >= 1 && c <= 4) || (c >= 9);
            g1 = (c >= 5 && c <= 8);
            check($sformatf("fair_c%0d_gnt0", c), 32'(gnt0), 32'(g0));
            check($sformatf("fair_c%0d_gnt1", c), 32'(gnt1), 32'(g1));
            check($sformatf("fair_c%0d_adr", c), mem_adr, g1 ? 32'h40 : 32'h00);
            check($sformatf("fair_c%0d_rvalid0", c), 32'(rvalid0), 32'(pg0));
            check($sformatf("fair_c%0d_rvalid1", c), 32'(rvalid1), 32'(pg1));
            if (pg0) check($sformatf("fair_c%0d_rd0", c), rd0, 32'hA500_0000);
            if (pg1) check($sformatf("fair_c%0d_rd1", c), rd1, 32'hA500_0010);
            check($sformatf("alt_c%0d_gnt0", c), 32'(b_gnt0), 32'(c >= 1 && (c % 2) == 1));
            check($sformatf("alt_c%0d_gnt1", c), 32'(b_gnt1), 32'(c >= 1 && (c % 2) == 0));
            pg0 = g0; pg1 = g1;
        end

        // Reset in the middle of a port-0 write burst
        we0 = 1'b1; adr0 = 32'h44; wd0 = 32'hBAD0_BAD0;
        #1;
        check("mid_pre_we", 32'(mem_we), 32'h1);
        reset = 1'b0;
        #1;
        check_reset_outputs("mid");
        check("mid_adr", mem_adr, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        req0 = 1'b0; we0 = 1'b0; adr0 = '0; wd0 = '0;
        req1 = 1'b0; adr1 = '0;
        tick(); #1;
        check("mid_post_state", 32'(dut.state), 32'(IDLE));
        check("mid_no_write", mem[17], 32'hA500_0011);

        // Solo burst on port 1 then a write while still owning
        for (int c = 0; c <= 10; c++) begin
            tick();
            if (c == 0) begin
                req1 = 1'b1; adr1 = 32'h20;
            end
            #1;
            check($sformatf("solo_c%0d_gnt1", c), 32'(gnt1), 32'(c >= 1));
            check($sformatf("solo_c%0d_gnt0", c), 32'(gnt0), 32'h0);
            if (c == 5 || c == 10)
                check($sformatf("solo_c%0d_cnt", c), 32'(dut.cnt), 32'h4);
        end
        tick();
        we1 = 1'b1; wd1 = 32'hDEAD_BEEF;
        #1;
        check("wr_gnt1", 32'(gnt1), 32'h1);
        check("wr_mem_we", 32'(mem_we), 32'h1);
        check("wr_mem_adr", mem_adr, 32'h20);
        check("wr_mem_wd", mem_wd, 32'hDEAD_BEEF);
        check("wr_prev_rvalid1", 32'(rvalid1), 32'h1);
        check("wr_prev_rd1", rd1, 32'hA500_0008);
        tick();
        req1 = 1'b0; we1 = 1'b0; wd1 = '0; adr1 = '0;
        #1;
        check("wr_after_we", 32'(mem_we), 32'h0);
        check("wr_no_rvalid1", 32'(rvalid1), 32'h0);
        check("wr_mem_word8", mem[8], 32'hDEAD_BEEF);
        tick(); #1;
        check("end_state", 32'(dut.state), 32'(IDLE));
        check("end_cnt", 32'(dut.cnt), 32'h0);
        check("end_prio", 32'(dut.prio), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter MAXBURST, default 4: maximum consecutive accesses an owner keeps while the other port requests.
REQ-002 Parameter WIDTH, default 32: address/data width.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 req0/req1  input  1  access request, port 0 = CPU, port 1 = loader/DMA.
REQ-006 we0/we1  input  1  write enable qualifying the request.
REQ-007 adr0/adr1  input  WIDTH  byte address (word aligned).
REQ-008 wd0/wd1  input  WIDTH  write data.
REQ-009 gnt0/gnt1  output  1  access performed this cycle for that port.
REQ-010 rvalid0/rvalid1  output  1  registered read data valid for the port's read accepted last cycle.
REQ-011 rd0/rd1  output  WIDTH  registered read data.
REQ-012 mem_we  output  1  write strobe to the shared single-port memory.
REQ-013 mem_adr/mem_wd  output  WIDTH  address/write data to memory.
REQ-014 mem_rd  input  WIDTH  combinational read data from memory.

Function
REQ-015 FSM states IDLE, OWN0 and OWN1 SHALL be held in a registered state variable.
REQ-016 gntN SHALL equal (state==OWNN && reqN); both grants SHALL never be 1 in the same cycle.
REQ-017 An access SHALL occur exactly in cycles with gntN=1: mem_adr=adrN, mem_wd=wdN, mem_we=weN.
REQ-018 With no grant, mem_we SHALL be 0 and mem_adr/mem_wd SHALL be 0.
REQ-019 A read accepted in cycle t SHALL produce rdN=mem_rd captured at t and rvalidN=1 in cycle t+1 only.
REQ-020 A write SHALL raise no rvalid.
REQ-021 IDLE: if exactly one req, next state SHALL be OWN of that port; if both, OWN of the port selected by priority pointer prio; if none, stay IDLE.
REQ-022 Request-to-first-grant latency from IDLE SHALL be 1 cycle.
REQ-023 OWNx with reqx=0: next state SHALL be OWNy if reqy, else IDLE, and prio SHALL be set to y.
REQ-024 OWNx with reqx=1: burst counter cnt SHALL increment per grant, saturating at MAXBURST.
REQ-025 When the access making cnt reach MAXBURST completes and reqy=1, next state SHALL be OWNy, with no idle gap; prio SHALL be set to x's opposite.
REQ-026 If reqy=0, the owner SHALL keep ownership indefinitely, with cnt held saturated.
REQ-027 cnt SHALL clear to 0 on every ownership change and on entry to IDLE.
REQ-028 MAXBURST=1 SHALL yield strict per-access alternation when both ports request.
REQ-029 Requesters SHALL hold req/we/adr/wd stable until gnt; the arbiter SHALL NOT buffer requests.

Reset
REQ-030 reset low SHALL immediately force state=IDLE, prio=port 0, cnt=0, gnt0/gnt1=0, rvalid0/rvalid1=0, rd0/rd1=0 and mem_we=0.
REQ-031 Reset asserted mid-burst SHALL abort with no further memory write; a pending rvalid SHALL be dropped.
REQ-032 The first grant after reset release SHALL follow REQ-021 rules from IDLE.

Structure
REQ-033 A shared package SHALL hold the state enum arb_state_t (IDLE, OWN0, OWN1) and the default MAXBURST constant.
REQ-034 The block SHALL be a single module with no sub-modules; memory stays external, wired beside mips in top.

Verification
REQ-035 Single read: req0=1 with adr0=0x10 and mem word 4=0x1234 -> gnt0 at cycle 1, rvalid0=1 with rd0=0x1234 at cycle 2.
REQ-036 Simultaneous: req0=req1=1 from IDLE after reset -> port 0 granted first, since prio=0.
REQ-037 Fairness: MAXBURST=4, both req held -> pattern of 4 gnt0, 4 gnt1, 4 gnt0, with no gap cycles.
REQ-038 Solo burst: only req1 held for 10 cycles -> gnt1 on 10 consecutive cycles after the 1-cycle latency; cnt saturated at 4.
REQ-039 Write: we1=1, adr1=0x20, wd1=0xDEADBEEF -> mem_we=1 for one cycle, no rvalid1, memory word 8=0xDEADBEEF.
REQ-040 Reset mid-burst: reset low during OWN0 -> gnt0, mem_we and rvalid0 are 0 before the next clk edge; after release, state is IDLE.
